// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared constants for the adder share arbiter
// Contents: FSM state encoding, default data width, requester-id width helper.
package adder_arb_pkg;

    localparam int DATA_W_DEF = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adder_share_arbiter_rr_picker.sv
// rtl/adder_share_arbiter_rr_picker.sv - combinational round-robin request picker
// Ports:
//   req_valid  in   per-requester request vector
//   rr_ptr     in   index with highest priority this round
//   grant      out  one-hot grant of the first request at or after rr_ptr (wrapping)
//   grant_idx  out  binary index of the granted requester
//   any        out  at least one request is present
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = |req_valid;
        // Scan from the farthest candidate to the nearest; the last hit
        // overwrites earlier ones, so the request closest to rr_ptr wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                grant = '0;
                grant[(int'(rr_ptr) + k) % NREQ] = 1'b1;
                grant_idx = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - shares one conditional-sum adder between NREQ requesters
// Optional feature macro: ADD_TIMEOUT_EN (WAIT-state timeout with rsp_err).
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-low reset
//   req_valid/req_opa/req_opb/req_sub   per-requester operation requests (flattened operands)
//   req_ready                    one-hot 1-cycle accept pulse
//   rsp_valid/rsp_id/rsp_sum/rsp_cout/rsp_ovf/rsp_err   shared 1-cycle response bus
//   busy                         high whenever the FSM is not IDLE
//   add_ope1/add_ope2/add_sub/add_start   registered drive to the adder
//   add_sum/add_cout/add_ovf/add_complete result from the adder
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int DATA_W = DATA_W_DEF
`ifdef ADD_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_opa,
    input  logic [NREQ*DATA_W-1:0]   req_opb,
    input  logic [NREQ-1:0]          req_sub,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    output logic [id_w(NREQ)-1:0]    rsp_id,
    output logic [DATA_W-1:0]        rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf,
    output logic                     rsp_err,
    output logic                     busy,
    output logic [DATA_W-1:0]        add_ope1,
    output logic [DATA_W-1:0]        add_ope2,
    output logic                     add_sub,
    output logic                     add_start,
    input  logic [DATA_W-1:0]        add_sum,
    input  logic                     add_cout,
    input  logic                     add_ovf,
    input  logic                     add_complete
);

    localparam int IDW = id_w(NREQ);

    logic [1:0]      state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  gnt_id;
    logic [NREQ-1:0] pick_grant;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic            timeout_hit;

    rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign busy = (state != ST_IDLE);

`ifdef ADD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] wait_cnt;
    // Fires on the TIMEOUT-th WAIT cycle so RESP is entered exactly
    // TIMEOUT cycles after WAIT entry.
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            gnt_id    <= '0;
            req_ready <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
            add_ope1  <= '0;
            add_ope2  <= '0;
            add_sub   <= 1'b0;
            add_start <= 1'b0;
`ifdef ADD_TIMEOUT_EN
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
`endif
        end else begin
            req_ready <= '0;
            add_start <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        req_ready <= pick_grant;
                        add_ope1  <= req_opa[int'(pick_idx)*DATA_W +: DATA_W];
                        add_ope2  <= req_opb[int'(pick_idx)*DATA_W +: DATA_W];
                        add_sub   <= req_sub[pick_idx];
                        gnt_id    <= pick_idx;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    add_start <= 1'b1;
                    state     <= ST_WAIT;
`ifdef ADD_TIMEOUT_EN
                    wait_cnt  <= '0;
`endif
                end
                ST_WAIT: begin
                    if (add_complete) begin
                        rsp_sum  <= add_sum;
                        rsp_cout <= add_cout;
                        rsp_ovf  <= add_ovf;
`ifdef ADD_TIMEOUT_EN
                        rsp_err  <= 1'b0;
`endif
                        state    <= ST_RESP;
                    end else if (timeout_hit) begin
                        rsp_sum  <= '0;
                        rsp_cout <= 1'b0;
                        rsp_ovf  <= 1'b0;
`ifdef ADD_TIMEOUT_EN
                        rsp_err  <= 1'b1;
`endif
                        state    <= ST_RESP;
                    end else begin
`ifdef ADD_TIMEOUT_EN
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                ST_RESP: begin
                    // Result strobe is registered out of RESP, so it lines up
                    // with the owner id and the already-latched result.
                    rsp_valid <= 1'b1;
                    rsp_id    <= gnt_id;
                    rr_ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - directed self-checking bench for adder_share_arbiter
module tb_adder_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int TMO  = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*DW-1:0] req_opa;
    logic [NREQ*DW-1:0] req_opb;
    logic [NREQ-1:0]   req_sub;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_sum;
    logic              rsp_cout;
    logic              rsp_ovf;
    logic              rsp_err;
    logic              busy;
    logic [DW-1:0]     add_ope1;
    logic [DW-1:0]     add_ope2;
    logic              add_sub;
    logic              add_start;
    logic [DW-1:0]     add_sum;
    logic              add_cout;
    logic              add_ovf;
    logic              add_complete;
    logic              model_complete;
    logic              stray_complete;
    logic              adder_en;

    int n_checks = 0;
    int n_pass   = 0;

    int          g_ord [8];
    int          n_g;
    int          r_id  [8];
    logic [63:0] r_sum [8];
    logic        r_cout[8];
    logic        r_ovf [8];
    logic        r_err [8];
    int          r_lat [8];
    int          n_r;

    always #5 clock = ~clock;

    assign add_complete = model_complete | stray_complete;

    adder_share_arbiter #(.NREQ(NREQ), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_opa(req_opa), .req_opb(req_opb), .req_sub(req_sub),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .busy(busy),
        .add_ope1(add_ope1), .add_ope2(add_ope2), .add_sub(add_sub), .add_start(add_start),
        .add_sum(add_sum), .add_cout(add_cout), .add_ovf(add_ovf), .add_complete(add_complete)
    );

    // Adder stand-in: complete one cycle after the start pulse.
    initial begin : adder_model
        logic [63:0] bb;
        logic [64:0] full;
        model_complete = 1'b0;
        add_sum  = '0;
        add_cout = 1'b0;
        add_ovf  = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (adder_en && add_start) begin
                bb   = add_sub ? ~add_ope2 : add_ope2;
                full = {1'b0, add_ope1} + {1'b0, bb} + {64'd0, add_sub};
                @(posedge clock); #1;
                add_sum  = full[63:0];
                add_cout = full[64];
                add_ovf  = (add_ope1[63] == bb[63]) && (full[63] != add_ope1[63]);
                model_complete = 1'b1;
                @(posedge clock); #1;
                model_complete = 1'b0;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        stray_complete = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b, input logic s);
        req_opa[i*DW +: DW] = a;
        req_opb[i*DW +: DW] = b;
        req_sub[i]   = s;
        req_valid[i] = 1'b1;
    endtask

    // Runs until n_exp responses arrive or the budget expires, dropping each
    // request as soon as it is accepted and logging grants and responses.
    task automatic collect(input int n_exp, input int budget);
        int c_ready;
        c_ready = 0;
        n_g = 0;
        n_r = 0;
        for (int k = 0; k < 8; k++) begin
            g_ord[k] = -1; r_id[k] = -1; r_sum[k] = 'x;
            r_cout[k] = 1'bx; r_ovf[k] = 1'bx; r_err[k] = 1'bx; r_lat[k] = -1;
        end
        for (int c = 0; c < budget && n_r < n_exp; c++) begin
            @(posedge clock); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] === 1'b1) begin
                    if (n_g < 8) g_ord[n_g] = i;
                    n_g++;
                    req_valid[i] = 1'b0;
                    c_ready = c;
                end
            end
            if (rsp_valid === 1'b1 && n_r < 8) begin
                r_id[n_r] = int'(rsp_id); r_sum[n_r] = rsp_sum; r_cout[n_r] = rsp_cout;
                r_ovf[n_r] = rsp_ovf; r_err[n_r] = rsp_err; r_lat[n_r] = c - c_ready;
                n_r++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (req_ready !== 4'b0) $display("FAIL reset_ready got=%b exp=0000", req_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else n_pass++;
        n_checks++; if (add_start !== 1'b0) $display("FAIL reset_add_start got=%b exp=0", add_start); else n_pass++;
        n_checks++; if (add_ope1 !== 64'd0) $display("FAIL reset_add_ope1 got=%h exp=0", add_ope1); else n_pass++;
        n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); else n_pass++;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_single();
        do_reset();
        set_req(0, 64'd2, 64'd2, 1'b0);
        collect(1, 40);
        n_checks++; if (n_g !== 1) $display("FAIL single_ready_pulses got=%0d exp=1", n_g); else n_pass++;
        n_checks++; if (r_id[0] !== 0) $display("FAIL single_id got=%0d exp=0", r_id[0]); else n_pass++;
        n_checks++; if (r_sum[0] !== 64'd4) $display("FAIL single_sum got=%h exp=4", r_sum[0]); else n_pass++;
        n_checks++; if (r_cout[0] !== 1'b0) $display("FAIL single_cout got=%b exp=0", r_cout[0]); else n_pass++;
        n_checks++; if (r_ovf[0] !== 1'b0) $display("FAIL single_ovf got=%b exp=0", r_ovf[0]); else n_pass++;
        n_checks++; if (r_err[0] !== 1'b0) $display("FAIL single_err got=%b exp=0", r_err[0]); else n_pass++;
        n_checks++; if (r_lat[0] !== 4) $display("FAIL single_latency got=%0d exp=4", r_lat[0]); else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 64'd25, 64'd25 + 64'(i), 1'b0);
        collect(4, 100);
        n_checks++; if (n_r !== 4) $display("FAIL rr_count got=%0d exp=4", n_r); else n_pass++;
        for (int i = 0; i < NREQ; i++) begin
            n_checks++; if (r_id[i] !== i) $display("FAIL rr_id%0d got=%0d exp=%0d", i, r_id[i], i); else n_pass++;
            n_checks++; if (r_sum[i] !== 64'd50 + 64'(i)) $display("FAIL rr_sum%0d got=%0d exp=%0d", i, r_sum[i], 50 + i); else n_pass++;
        end
        // Grant req1 so the pointer moves to 2, then req2 must beat req0.
        do_reset();
        set_req(1, 64'd7, 64'd8, 1'b0);
        collect(1, 40);
        set_req(0, 64'd1, 64'd1, 1'b0);
        set_req(2, 64'd3, 64'd3, 1'b0);
        collect(2, 60);
        n_checks++; if (g_ord[0] !== 2) $display("FAIL rr_ptr_first got=%0d exp=2", g_ord[0]); else n_pass++;
        n_checks++; if (g_ord[1] !== 0) $display("FAIL rr_ptr_wrap got=%0d exp=0", g_ord[1]); else n_pass++;
        n_checks++; if (r_sum[0] !== 64'd6) $display("FAIL rr_ptr_sum got=%0d exp=6", r_sum[0]); else n_pass++;
    endtask

    task automatic test_sub_ovf();
        set_req(3, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        collect(1, 40);
        n_checks++; if (r_id[0] !== 3) $display("FAIL sub_id got=%0d exp=3", r_id[0]); else n_pass++;
        n_checks++; if (r_sum[0] !== 64'h7FFF_FFFF_FFFF_FFFF) $display("FAIL sub_sum got=%h exp=7fffffffffffffff", r_sum[0]); else n_pass++;
        n_checks++; if (r_ovf[0] !== 1'b1) $display("FAIL sub_ovf got=%b exp=1", r_ovf[0]); else n_pass++;
        n_checks++; if (r_cout[0] !== 1'b1) $display("FAIL sub_cout got=%b exp=1", r_cout[0]); else n_pass++;
    endtask

    task automatic test_add_carry();
        set_req(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        collect(1, 40);
        n_checks++; if (r_sum[0] !== 64'd0) $display("FAIL carry_sum got=%h exp=0", r_sum[0]); else n_pass++;
        n_checks++; if (r_cout[0] !== 1'b1) $display("FAIL carry_cout got=%b exp=1", r_cout[0]); else n_pass++;
        n_checks++; if (r_ovf[0] !== 1'b0) $display("FAIL carry_ovf got=%b exp=0", r_ovf[0]); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        logic seen_ready, seen_valid, seen_busy;
        do_reset();
        adder_en = 1'b0;
        seen_ready = 1'b0;
        set_req(0, 64'h1234, 64'h1111, 1'b0);
        for (int c = 0; c < 20 && !seen_ready; c++) begin
            @(posedge clock); #1;
            if (req_ready[0] === 1'b1) begin seen_ready = 1'b1; req_valid[0] = 1'b0; end
        end
        n_checks++; if (seen_ready !== 1'b1) $display("FAIL rstw_grant got=%b exp=1", seen_ready); else n_pass++;
        repeat (2) @(posedge clock);
        #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL rstw_busy_before got=%b exp=1", busy); else n_pass++;
        #2 reset = 1'b0;
        @(posedge clock); #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstw_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (add_ope1 !== 64'd0) $display("FAIL rstw_ope1 got=%h exp=0", add_ope1); else n_pass++;
        n_checks++; if (add_ope2 !== 64'd0) $display("FAIL rstw_ope2 got=%h exp=0", add_ope2); else n_pass++;
        reset = 1'b1;
        seen_valid = 1'b0;
        seen_busy  = 1'b0;
        stray_complete = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            if (c == 3) stray_complete = 1'b0;
            if (rsp_valid !== 1'b0) seen_valid = 1'b1;
            if (busy !== 1'b0) seen_busy = 1'b1;
        end
        n_checks++; if (seen_valid !== 1'b0) $display("FAIL rstw_stray_rsp got=%b exp=0", seen_valid); else n_pass++;
        n_checks++; if (seen_busy !== 1'b0) $display("FAIL rstw_stray_busy got=%b exp=0", seen_busy); else n_pass++;
        adder_en = 1'b1;
    endtask

`ifdef ADD_TIMEOUT_EN
    task automatic test_timeout();
        int c_start, c_err, c_valid;
        logic [63:0] v_sum;
        logic v_err;
        do_reset();
        adder_en = 1'b0;
        c_start = -1; c_err = -1; c_valid = -1;
        v_sum = 'x; v_err = 1'bx;
        set_req(2, 64'd5, 64'd6, 1'b0);
        for (int c = 0; c < 60 && c_valid < 0; c++) begin
            @(posedge clock); #1;
            if (req_ready[2] === 1'b1) req_valid[2] = 1'b0;
            if (add_start === 1'b1 && c_start < 0) c_start = c;
            if (rsp_err === 1'b1 && c_err < 0) c_err = c;
            if (rsp_valid === 1'b1) begin c_valid = c; v_sum = rsp_sum; v_err = rsp_err; end
        end
        n_checks++; if (c_err - c_start !== TMO) $display("FAIL tmo_err_cycle got=%0d exp=%0d", c_err - c_start, TMO); else n_pass++;
        n_checks++; if (c_valid - c_err !== 1) $display("FAIL tmo_valid_cycle got=%0d exp=1", c_valid - c_err); else n_pass++;
        n_checks++; if (v_err !== 1'b1) $display("FAIL tmo_err got=%b exp=1", v_err); else n_pass++;
        n_checks++; if (v_sum !== 64'd0) $display("FAIL tmo_sum got=%h exp=0", v_sum); else n_pass++;
        adder_en = 1'b1;
    endtask
`endif

    initial begin
        adder_en = 1'b1;
        stray_complete = 1'b0;
        reset = 1'b0;
        req_valid = '0;
        req_opa = '0;
        req_opb = '0;
        req_sub = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_sub_ovf();
        test_add_carry();
        test_reset_in_wait();
`ifdef ADD_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
